// File: rtl/k6502_seq.sv
// 6502-style instruction sequencer: one-hot cycle counter, IR load, and reset/NMI/IRQ sequence selection.
// Define K6502_PIN_SYNC_EN to pass nmi_n and irq_n through two-flop synchronizers.
module k6502_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic [7:0] din,
    input  logic [7:0] sr,
    input  logic       sync_next,
    input  logic       nmi_n,
    input  logic       irq_n,
    output logic [7:0] ir,
    output logic [5:0] cycle,
    output logic       rst,
    output logic       nmi,
    output logic       irq,
    output logic       halt
);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_SHIFT,
        ACT_OVERRUN,
        ACT_NMI,
        ACT_IRQ,
        ACT_FETCH
    } act_e;

    localparam logic [5:0] C0 = 6'b000001;
    localparam logic [5:0] CN = 6'b000000;

    logic       nmiPin;
    logic       irqPin;

    logic [7:0] ir_q,      ir_d;
    logic [5:0] cycle_q,   cycle_d;
    logic       rst_q,     rst_d;
    logic       nmi_q,     nmi_d;
    logic       irq_q,     irq_d;
    logic       halt_q,    halt_d;
    logic       nmiPend_q, nmiPend_d;
    logic       nmiPrev_q;

    logic       nmiFall;
    logic       irqRequest;
    act_e       act;

    logic       unusedSr;
    assign unusedSr = ^{sr[7:3], sr[1:0]};

`ifdef K6502_PIN_SYNC_EN
    logic [1:0] nmiSync_q;
    logic [1:0] irqSync_q;

    // Synchronizers idle high so reset never looks like a pin event.
    always_ff @(posedge clk) begin
        if (reset) begin
            nmiSync_q <= 2'b11;
            irqSync_q <= 2'b11;
        end else begin
            nmiSync_q <= {nmiSync_q[0], nmi_n};
            irqSync_q <= {irqSync_q[0], irq_n};
        end
    end

    assign nmiPin = nmiSync_q[1];
    assign irqPin = irqSync_q[1];
`else
    assign nmiPin = nmi_n;
    assign irqPin = irq_n;
`endif

    assign nmiFall    = nmiPrev_q & ~nmiPin;
    assign irqRequest = ~irqPin & ~sr[2];

    always_comb begin
        act = ACT_HOLD;
        if (!halt_q && rdy) begin
            if (cycle_q == CN || (cycle_q[5] && !sync_next)) begin
                act = ACT_OVERRUN;
            end else if (sync_next) begin
                if (nmiPend_q) begin
                    act = ACT_NMI;
                end else if (irqRequest) begin
                    act = ACT_IRQ;
                end else begin
                    act = ACT_FETCH;
                end
            end else begin
                act = ACT_SHIFT;
            end
        end
    end

    always_comb begin
        ir_d    = ir_q;
        cycle_d = cycle_q;
        rst_d   = rst_q;
        nmi_d   = nmi_q;
        irq_d   = irq_q;
        halt_d  = halt_q;

        case (act)
            ACT_SHIFT: begin
                cycle_d = {cycle_q[4:0], 1'b0};
            end
            ACT_OVERRUN: begin
                cycle_d = CN;
                halt_d  = 1'b1;
            end
            ACT_NMI: begin
                ir_d    = 8'h00;
                cycle_d = C0;
                rst_d   = 1'b0;
                nmi_d   = 1'b1;
                irq_d   = 1'b0;
            end
            ACT_IRQ: begin
                ir_d    = 8'h00;
                cycle_d = C0;
                rst_d   = 1'b0;
                nmi_d   = 1'b0;
                irq_d   = 1'b1;
            end
            ACT_FETCH: begin
                ir_d    = din;
                cycle_d = C0;
                rst_d   = 1'b0;
                nmi_d   = 1'b0;
                irq_d   = 1'b0;
            end
            default: begin
            end
        endcase

        // A fresh falling edge on the same clock as the clear must win.
        nmiPend_d = nmiFall | (nmiPend_q & (act != ACT_NMI));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q      <= 8'h00;
            cycle_q   <= C0;
            rst_q     <= 1'b1;
            nmi_q     <= 1'b0;
            irq_q     <= 1'b0;
            halt_q    <= 1'b0;
            nmiPend_q <= 1'b0;
            nmiPrev_q <= 1'b1;
        end else begin
            ir_q      <= ir_d;
            cycle_q   <= cycle_d;
            rst_q     <= rst_d;
            nmi_q     <= nmi_d;
            irq_q     <= irq_d;
            halt_q    <= halt_d;
            nmiPend_q <= nmiPend_d;
            nmiPrev_q <= nmiPin;
        end
    end

    assign ir    = ir_q;
    assign cycle = cycle_q;
    assign rst   = rst_q;
    assign nmi   = nmi_q;
    assign irq   = irq_q;
    assign halt  = halt_q;

endmodule

// File: tb/tb_k6502_seq.sv
// Self-checking bench for k6502_seq: directed scenarios then random steps against a behavioural model.
// The model tracks the cycle as an index and the sequence kind as a small integer.
module tb_k6502_seq;

    logic       clk;
    logic       reset;
    logic       rdy;
    logic [7:0] din;
    logic [7:0] sr;
    logic       sync_next;
    logic       nmi_n;
    logic       irq_n;
    logic [7:0] ir;
    logic [5:0] cycle;
    logic       rst;
    logic       nmi;
    logic       irq;
    logic       halt;

    int testsRun;
    int failCount;

    // Model: cycle index 0..5, -1 for C_N; kind 0=NON 1=RST 2=NMI 3=IRQ
    logic [7:0] mIr;
    int         mCyc;
    int         mKind;
    logic       mHalt;
    logic       mPend;
    logic       mPrev;
    logic       nLine [2];
    logic       iLine [2];

    k6502_seq dut (
        .clk       (clk),
        .reset     (reset),
        .rdy       (rdy),
        .din       (din),
        .sr        (sr),
        .sync_next (sync_next),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .ir        (ir),
        .cycle     (cycle),
        .rst       (rst),
        .nmi       (nmi),
        .irq       (irq),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string tag, input string field,
                              input logic [7:0] obs, input logic [7:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [5:0] eCyc;
        eCyc = (mCyc < 0) ? 6'd0 : 6'(1 << mCyc);
        checkField(tag, "ir",    ir,           mIr);
        checkField(tag, "cycle", {2'b0, cycle}, {2'b0, eCyc});
        checkField(tag, "rst",   {7'b0, rst},  {7'b0, (mKind == 1)});
        checkField(tag, "nmi",   {7'b0, nmi},  {7'b0, (mKind == 2)});
        checkField(tag, "irq",   {7'b0, irq},  {7'b0, (mKind == 3)});
        checkField(tag, "halt",  {7'b0, halt}, {7'b0, mHalt});
    endtask

    task automatic modelStep();
        logic effN;
        logic effI;
        logic fall;
        logic takeNmi;
        if (reset) begin
            mIr   = 8'h00;
            mCyc  = 0;
            mKind = 1;
            mHalt = 1'b0;
            mPend = 1'b0;
            mPrev = 1'b1;
            for (int k = 0; k < 2; k++) begin
                nLine[k] = 1'b1;
                iLine[k] = 1'b1;
            end
            return;
        end
`ifdef K6502_PIN_SYNC_EN
        effN = nLine[1];
        effI = iLine[1];
        nLine[1] = nLine[0];
        nLine[0] = nmi_n;
        iLine[1] = iLine[0];
        iLine[0] = irq_n;
`else
        effN = nmi_n;
        effI = irq_n;
`endif
        fall    = mPrev && !effN;
        takeNmi = 1'b0;
        if (!mHalt && rdy) begin
            if (sync_next && mCyc >= 0) begin
                mCyc = 0;
                if (mPend) begin
                    mKind   = 2;
                    mIr     = 8'h00;
                    takeNmi = 1'b1;
                end else if (!effI && !sr[2]) begin
                    mKind = 3;
                    mIr   = 8'h00;
                end else begin
                    mKind = 0;
                    mIr   = din;
                end
            end else if (mCyc == 5 || mCyc < 0) begin
                mCyc  = -1;
                mHalt = 1'b1;
            end else begin
                mCyc = mCyc + 1;
            end
        end
        if (fall)         mPend = 1'b1;
        else if (takeNmi) mPend = 1'b0;
        mPrev = effN;
    endtask

    task automatic applyStimulus(input logic rs, input logic rd, input logic sn,
                                 input logic [7:0] d, input logic [7:0] s,
                                 input logic nn, input logic inn, input string tag);
        reset     = rs;
        rdy       = rd;
        sync_next = sn;
        din       = d;
        sr        = s;
        nmi_n     = nn;
        irq_n     = inn;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        reset = 1'b1; rdy = 1'b1; sync_next = 1'b0; din = 8'h00;
        sr = 8'h00; nmi_n = 1'b1; irq_n = 1'b1;

        // Reset state, with junk on the other inputs
        applyStimulus(1, 0, 1, 8'h55, 8'h00, 0, 0, "reset0");
        applyStimulus(1, 1, 1, 8'h33, 8'h00, 1, 1, "reset1");
        checkField("resetConst", "cycle", {2'b0, cycle}, 8'h01);
        checkField("resetConst", "rst",   {7'b0, rst},   8'h01);

        // Reset sequence runs C0..C4 then fetches EA
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 1, 0, 8'h00, 8'h04, 1, 1, "rstSeq");
        applyStimulus(0, 1, 1, 8'hEA, 8'h04, 1, 1, "rstEnd");
        checkField("rstEndConst", "ir",    ir,             8'hEA);
        checkField("rstEndConst", "cycle", {2'b0, cycle},  8'h01);
        checkField("rstEndConst", "mode",  {5'b0, rst, nmi, irq}, 8'h00);

        // Opcode AD, three shifts, then fetch A9
        applyStimulus(0, 1, 1, 8'hAD, 8'h04, 1, 1, "fetchAD");
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 1, 0, 8'h11, 8'h04, 1, 1, "shiftAD");
        checkField("shiftConst", "cycle", {2'b0, cycle}, 8'h08);
        applyStimulus(0, 1, 1, 8'hA9, 8'h04, 1, 1, "fetchA9");
        checkField("fetchA9Const", "ir", ir, 8'hA9);

        // IRQ masked, then unmasked
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 1, 0, 8'h00, 8'h04, 1, 0, "irqMaskWait");
        applyStimulus(0, 1, 1, 8'h18, 8'h04, 1, 0, "irqMasked");
        checkField("irqMaskedConst", "irq", {7'b0, irq}, 8'h00);
        for (int k = 0; k < 2; k++)
            applyStimulus(0, 1, 0, 8'h00, 8'h00, 1, 0, "irqWait");
        applyStimulus(0, 1, 1, 8'h18, 8'h00, 1, 0, "irqTaken");
        checkField("irqTakenConst", "irq", {7'b0, irq}, 8'h01);
        checkField("irqTakenConst", "ir",  ir,          8'h00);
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 1, 0, 8'h00, 8'h00, 1, 1, "irqSeq");
        applyStimulus(0, 1, 1, 8'hEA, 8'h00, 1, 1, "irqEnd");

        // NMI pulse beats a pending IRQ; a held-low pin gives no second NMI
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 1, 0, "nmiPre");
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 0, "nmiPulse");
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 1, 0, "nmiPost1");
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 1, 0, "nmiPost2");
        applyStimulus(0, 1, 1, 8'h77, 8'h00, 1, 0, "nmiTaken");
        checkField("nmiTakenConst", "nmi", {7'b0, nmi}, 8'h01);
        checkField("nmiTakenConst", "irq", {7'b0, irq}, 8'h00);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 1, 0, 8'h00, 8'h04, 0, 1, "nmiHeld");
            applyStimulus(0, 1, 0, 8'h00, 8'h04, 0, 1, "nmiHeld");
            applyStimulus(0, 1, 1, 8'h4C, 8'h04, 0, 1, "nmiHeldFetch");
        end
        checkField("nmiHeldConst", "nmi", {7'b0, nmi}, 8'h00);
        applyStimulus(0, 1, 0, 8'h00, 8'h04, 1, 1, "nmiRelease");
        applyStimulus(0, 1, 1, 8'hEA, 8'h04, 1, 1, "nmiRelFetch");

        // rdy low at C2 with an NMI edge during the stall
        applyStimulus(0, 1, 0, 8'h00, 8'h04, 1, 1, "stallC1");
        applyStimulus(0, 1, 0, 8'h00, 8'h04, 1, 1, "stallC2");
        applyStimulus(0, 0, 1, 8'h99, 8'h04, 0, 1, "stall0");
        applyStimulus(0, 0, 0, 8'h99, 8'h04, 1, 1, "stall1");
        applyStimulus(0, 0, 1, 8'h99, 8'h04, 1, 1, "stall2");
        checkField("stallConst", "cycle", {2'b0, cycle}, 8'h04);
        applyStimulus(0, 1, 0, 8'h00, 8'h04, 1, 1, "stallResume");
        applyStimulus(0, 1, 1, 8'h99, 8'h04, 1, 1, "stallNmi");
        checkField("stallNmiConst", "nmi", {7'b0, nmi}, 8'h01);

        // Overrun: six shifting edges from C0, then everything ignored
        for (int k = 0; k < 6; k++)
            applyStimulus(0, 1, 0, 8'h00, 8'h00, 1, 1, "overrun");
        checkField("overrunConst", "cycle", {2'b0, cycle}, 8'h00);
        checkField("overrunConst", "halt",  {7'b0, halt},  8'h01);
        for (int k = 0; k < 4; k++)
            applyStimulus(0, k[0], 1, 8'hC3, 8'h00, k[1], 0, "haltHold");
        applyStimulus(1, 1, 1, 8'h00, 8'h00, 1, 1, "haltReset");

        // Random phase, including mid-sequence resets
        for (int k = 0; k < 600; k++) begin
            logic rs;
            rs = ($urandom_range(99) < 2) || (mHalt && $urandom_range(7) == 0);
            applyStimulus(rs,
                          $urandom_range(9) < 8,
                          $urandom_range(2) == 0,
                          8'($urandom),
                          8'($urandom),
                          $urandom_range(5) != 0,
                          1'($urandom),
                          "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/k6502_seq.md
K6502_SEQ -- requirements
Module: k6502_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL declare ports as listed:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  synchronous active-high reset.
- rdy  input  1  high = advance; low = hold sequencer state.
- din  input  8  data bus read value; opcode source.
- sr  input  8  status register; bit 2 = I (IRQ mask).
- sync_next  input  1  from microcode word; last cycle of current sequence.
- nmi_n  input  1  NMI pin, active-low, edge-triggered.
- irq_n  input  1  IRQ pin, active-low, level-sensitive.
- ir  output  8  instruction register to microcode decode.
- cycle  output  6  one-hot cycle; 000001=C0 .. 100000=C5; 000000=C_N.
- rst  output  1  reset sequence active.
- nmi  output  1  NMI sequence active.
- irq  output  1  IRQ sequence active.
- halt  output  1  sequencer overrun; sticky until reset.

Function
REQ-003 SHALL keep {rst,nmi,irq} at most one-hot; 000 = normal instruction (NON).
REQ-004 SHALL advance only on clock edges with rdy=1; with rdy=0, ir, cycle, mode, halt hold.
REQ-005 SHALL, on an advancing edge with sync_next=0, shift cycle left one position.
REQ-006 SHALL, on an advancing edge with sync_next=1, end the sequence and select the next one by priority: NMI pending > IRQ > opcode fetch.
REQ-007 NMI selected: nmi<=1, rst<=0, irq<=0, ir<=8'h00, cycle<=C0, and the NMI pending flag cleared.
REQ-008 IRQ selected when irq_n=0 and sr[2]=0: irq<=1, other mode bits 0, ir<=8'h00, cycle<=C0.
REQ-009 Otherwise: ir<=din, mode<=000, cycle<=C0.
REQ-010 SHALL sample IRQ only at sequence end; an IRQ deasserted before that edge is lost.
REQ-011 SHALL set the NMI pending flag on a falling edge of nmi_n. Edge detection runs every clock, regardless of rdy.
REQ-012 SHALL keep pending set when a new falling edge coincides with the clearing edge.
REQ-013 SHALL treat a held-low nmi_n as one event; re-arm only after nmi_n returns high.
REQ-014 On an advancing edge with cycle=C5 and sync_next=0: cycle<=000000, halt<=1.
REQ-015 While halt=1: ignore sync_next, rdy and interrupts; hold ir and mode.
REQ-016 SHALL, with cycle=000000 and halt=0 (not reachable except via X), treat the state as an overrun (per REQ-014).
REQ-017 SHALL drive all outputs directly from registers; the only combinational path is to next state.

Reset
REQ-018 Reset on a clock edge SHALL override rdy, sync_next and interrupts, including mid-sequence.
REQ-019 Reset values: ir=8'h00, cycle=C0, rst=1, nmi=0, irq=0, halt=0, NMI pending=0, nmi_n edge history=1 (high).
REQ-020 SHALL keep rst=1 through the reset sequence until its sync_next edge; selection then follows REQ-006.

Configuration
REQ-021 With macro K6502_PIN_SYNC_EN defined:
- nmi_n and irq_n each pass through a two-flop synchronizer reset to 1.
- Edge detection and IRQ sampling use the synchronized values, adding 2 clocks of pin latency.
REQ-022 With K6502_PIN_SYNC_EN undefined: pins are used directly, with no added latency; all other behaviour is identical.

Verification
REQ-023 Reset release, sync_next=1 at C4, din=8'hEA -> rst falls, ir=8'hEA, cycle=C0, mode=000.
REQ-024 Opcode 8'hAD, sync_next=0 for 3 edges then 1, din=8'hA9 -> cycle C0,C1,C2,C3, then ir=8'hA9, cycle=C0.
REQ-025 irq_n=0, sr=8'h04 at sync -> opcode fetched, irq=0; repeat with sr=8'h00 -> irq=1, ir=8'h00.
REQ-026 Single nmi_n low pulse mid-instruction with irq_n=0, sr=8'h00 -> at sync nmi=1 (not irq); pending cleared. nmi_n held low afterwards -> no second NMI.
REQ-027 sync_next held 0 for 6 advancing edges from C0 -> cycle=000000, halt=1; din/sync_next/irq_n then ignored until reset.
REQ-028 rdy=0 for 3 clocks at C2 with a nmi_n falling edge -> cycle stays C2; NMI taken at the next sync after rdy=1. Repeat with and without K6502_PIN_SYNC_EN.
